// File: rtl/fifo_rd_stream_pkg.sv
// Shared types and width helpers for the fifo_rd_stream read-side drain engine.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int STATS_W = 32;

  // Counter width able to hold the values 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream of the drain engine.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_rden;
  logic                  fifo_rempty;
  logic [DATA_WIDTH-1:0] fifo_rdata;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;

  modport master (
    output fifo_rden,
    input  fifo_rempty,
    input  fifo_rdata,
    output m_valid,
    input  m_ready,
    output m_data
  );

  modport slave (
    input  fifo_rden,
    output fifo_rempty,
    output fifo_rdata,
    input  m_valid,
    output m_ready,
    input  m_data
  );
endinterface

// File: rtl/fifo_rd_stream_buf.sv
// In-order output buffer (BUF_DEPTH x DATA_WIDTH) with registered head word.
// Pointers compare-and-clear so BUF_DEPTH need not be a power of two.
module stream_buf_fifo
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = cnt_width(BUF_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [CNT_WIDTH-1:0]  occ,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  full,
  output logic                  not_empty
);

  localparam int PTR_W = ptr_width(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0]  occ_q, occ_d;
  logic                  pop_ok_s;
  logic                  push_ok_s;

  assign occ       = occ_q;
  assign head      = mem_q[rd_ptr_q];
  assign full      = (occ_q == CNT_WIDTH'(BUF_DEPTH));
  assign not_empty = (occ_q != '0);

  // Qualify requests; a write into a full buffer is only legal alongside a pop.
  always_comb begin
    pop_ok_s  = pop & not_empty;
    push_ok_s = push & (~full | pop_ok_s);
  end

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = push_data;
      if (wr_ptr_q == PTR_W'(BUF_DEPTH - 1)) begin
        wr_ptr_d = '0;
      end else begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      if (rd_ptr_q == PTR_W'(BUF_DEPTH - 1)) begin
        rd_ptr_d = '0;
      end else begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   occ_d = occ_q + CNT_WIDTH'(1);
      2'b01:   occ_d = occ_q - CNT_WIDTH'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared on reset so the head word reads zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_rd_stream_chk.sv
// Parameter and protocol checks for fifo_rd_stream.
module fifo_rd_stream_chk #(
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4
) (
  input logic clk,
  input logic reset,
  input logic rden,
  input logic rempty,
  input logic push,
  input logic pop,
  input logic full
);

  if ((RD_LATENCY < 1) || (RD_LATENCY > 4)) begin : g_bad_latency
    $error("fifo_rd_stream: RD_LATENCY must be within 1..4");
  end

  if (BUF_DEPTH < (RD_LATENCY + 1)) begin : g_bad_depth
    $error("fifo_rd_stream: BUF_DEPTH must be at least RD_LATENCY+1");
  end

  // Read strobes against an empty FIFO and buffer overflow are design errors.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(rden && rempty)) else $error("fifo_rd_stream: read strobe while FIFO empty");
      assert (!(push && full && !pop)) else $error("fifo_rd_stream: output buffer overflow");
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain drain engine: credit-checked FIFO reads, latency pipe, output stream.
// Optional FIFO_RD_STREAM_STATS_EN adds beat_count / stall_count outputs.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = 4,
  parameter int CNT_WIDTH  = cnt_width(BUF_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  fifo_rd_stream_if.master        bus,
  output logic                    idle
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STATS_W-1:0]      beat_count,
  output logic [STATS_W-1:0]      stall_count
`endif
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_RUN   = ST_RUN;
  localparam logic [1:0] S_DRAIN = ST_DRAIN;
  localparam int         SUM_W   = CNT_WIDTH + 2;

  logic [1:0]            state_q, state_d;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [CNT_WIDTH-1:0]  occ_s;
  logic [CNT_WIDTH-1:0]  inflight_s;
  logic [SUM_W-1:0]      commit_s;
  logic                  rden_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  full_s;
  logic                  not_empty_s;
  logic                  drained_s;

  assign push_s        = pipe_q[RD_LATENCY-1];
  assign pop_s         = not_empty_s & bus.m_ready;
  assign bus.m_valid   = not_empty_s;
  assign bus.fifo_rden = rden_s;
  assign idle          = (state_q == S_IDLE);

  // Reads still travelling through the SRAM latency.
  always_comb begin
    inflight_s = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight_s = inflight_s + CNT_WIDTH'(pipe_q[i]);
    end
  end

  // Issue only if the word is guaranteed a buffer slot when it lands.
  always_comb begin
    commit_s = SUM_W'(occ_s) + SUM_W'(inflight_s) - SUM_W'(pop_s);
    if ((state_q == S_RUN) && !bus.fifo_rempty && (commit_s < SUM_W'(BUF_DEPTH))) begin
      rden_s = 1'b1;
    end else begin
      rden_s = 1'b0;
    end
  end

  // Latency pipe: a 1 enters per read and marks rdata valid at the tail.
  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = rden_s;
    for (int i = 1; i < RD_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Drain completes once nothing is in flight and the last beat leaves.
  always_comb begin
    if ((inflight_s == '0) &&
        ((occ_s == '0) || ((occ_s == CNT_WIDTH'(1)) && pop_s))) begin
      drained_s = 1'b1;
    end else begin
      drained_s = 1'b0;
    end
  end

  // Control FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RUN;
        else        state_d = S_IDLE;
      end
      S_RUN: begin
        if (!enable) state_d = S_DRAIN;
        else         state_d = S_RUN;
      end
      S_DRAIN: begin
        if (enable)         state_d = S_RUN;
        else if (drained_s) state_d = S_IDLE;
        else                state_d = S_DRAIN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= pipe_d;
    end
  end

  stream_buf_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH),
    .CNT_WIDTH  (CNT_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (push_s),
    .push_data (bus.fifo_rdata),
    .pop       (pop_s),
    .occ       (occ_s),
    .head      (bus.m_data),
    .full      (full_s),
    .not_empty (not_empty_s)
  );

  fifo_rd_stream_chk #(
    .RD_LATENCY (RD_LATENCY),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_chk (
    .clk    (clk),
    .reset  (reset),
    .rden   (rden_s),
    .rempty (bus.fifo_rempty),
    .push   (push_s),
    .pop    (pop_s),
    .full   (full_s)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  logic [STATS_W-1:0] beat_count_q, beat_count_d;
  logic [STATS_W-1:0] stall_count_q, stall_count_d;

  assign beat_count  = beat_count_q;
  assign stall_count = stall_count_q;

  // Beat counter wraps; stall counter saturates.
  always_comb begin
    if (pop_s) beat_count_d = beat_count_q + 32'd1;
    else       beat_count_d = beat_count_q;
    if (not_empty_s && !bus.m_ready && (stall_count_q != 32'hFFFF_FFFF)) begin
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_count_q  <= '0;
      stall_count_q <= '0;
    end else begin
      beat_count_q  <= beat_count_d;
      stall_count_q <= stall_count_d;
    end
  end
`endif

endmodule
